// File: rtl/nearest_hit_tracker.sv
// Streaming nearest-hit reducer: folds one ray's triangle intersection results
// into the closest positive-distance hit and presents it until the consumer takes it.
module nearest_hit_tracker #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_t,
    input  logic [1:0]              in_code,
    input  logic [IDX_W-1:0]        in_idx,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_hit,
    output logic signed [WIDTH-1:0] out_t,
    output logic [IDX_W-1:0]        out_idx,
    output logic [IDX_W-1:0]        out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [1:0]              CODE_HIT = 2'b01;
    localparam logic signed [WIDTH-1:0] T_ZERO   = '0;
    localparam logic [IDX_W-1:0]        CNT_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t                    state_q, state_d;
    logic                      best_hit_q, best_hit_d;
    logic signed [WIDTH-1:0]   best_t_q, best_t_d;
    logic [IDX_W-1:0]          best_idx_q, best_idx_d;
    logic [IDX_W-1:0]          count_q, count_d;

    logic accept;
    logic qualify;

    always_comb begin
        state_d    = state_q;
        best_hit_d = best_hit_q;
        best_t_d   = best_t_q;
        best_idx_d = best_idx_q;
        count_d    = count_q;

        in_ready = (state_q != HOLD);
        accept   = in_valid && in_ready;
        qualify  = (in_code == CODE_HIT) && (in_t > T_ZERO);

        case (state_q)
            IDLE: begin
                // The first result always seeds the accumulator; a non-qualifying
                // seed is harmless because best_hit gates every later use of it.
                if (accept) begin
                    best_hit_d = qualify;
                    best_t_d   = in_t;
                    best_idx_d = in_idx;
                    count_d    = CNT_ONE;
                    state_d    = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    // Strict less-than keeps the earlier triangle on equal distance.
                    if (qualify && (!best_hit_q || (in_t < best_t_q))) begin
                        best_hit_d = 1'b1;
                        best_t_d   = in_t;
                        best_idx_d = in_idx;
                    end
                    if (count_q != '1) begin
                        count_d = count_q + CNT_ONE;
                    end
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            best_hit_q <= 1'b0;
            best_t_q   <= '0;
            best_idx_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            best_hit_q <= best_hit_d;
            best_t_q   <= best_t_d;
            best_idx_q <= best_idx_d;
            count_q    <= count_d;
        end
    end

    // Result fields are forced to zero outside HOLD and on a miss so stale
    // accumulator contents never leak to the consumer.
    always_comb begin
        out_valid = (state_q == HOLD);
        out_hit   = out_valid && best_hit_q;
        out_t     = out_hit ? best_t_q : T_ZERO;
        out_idx   = out_hit ? best_idx_q : '0;
        out_count = out_valid ? count_q : '0;
    end

endmodule

// File: tb/tb_nearest_hit_tracker.sv
// Directed bench for nearest_hit_tracker: expected per-ray results go into a
// scoreboard queue as stimulus is driven and are compared when out_valid appears.
module tb_nearest_hit_tracker;

    localparam int WIDTH = 32;
    localparam int IDX_W = 10;
    localparam int ONE   = 1 << 16;

    typedef struct {
        logic                    hit;
        logic signed [WIDTH-1:0] t;
        logic [IDX_W-1:0]        idx;
        logic [IDX_W-1:0]        count;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_t;
    logic [1:0]              in_code;
    logic [IDX_W-1:0]        in_idx;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_hit;
    logic signed [WIDTH-1:0] out_t;
    logic [IDX_W-1:0]        out_idx;
    logic [IDX_W-1:0]        out_count;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    nearest_hit_tracker #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_t      (in_t),
        .in_code   (in_code),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hit   (out_hit),
        .out_t     (out_t),
        .out_idx   (out_idx),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one result at the current negedge; it is accepted on the next posedge.
    task automatic send(input logic [1:0] code, input int t, input int idx, input logic last);
        chk("send_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_code  = code;
        in_t     = t;
        in_idx   = IDX_W'(idx);
        in_last  = last;
        @(negedge clk);
    endtask

    task automatic push(input logic hit, input int t, input int idx, input int count);
        exp_t e;
        e.hit   = hit;
        e.t     = t;
        e.idx   = IDX_W'(idx);
        e.count = IDX_W'(count);
        sb.push_back(e);
    endtask

    task automatic wait_check(input string tag);
        int   waited;
        exp_t e;
        waited = 0;
        while (!out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_hit"}, {63'd0, out_hit}, {63'd0, e.hit});
            chk({tag, "_t"}, {32'd0, out_t}, {32'd0, e.t});
            chk({tag, "_idx"}, {54'd0, out_idx}, {54'd0, e.idx});
            chk({tag, "_count"}, {54'd0, out_count}, {54'd0, e.count});
            $display("ray %s: hit=%0b t=%0h idx=%0d count=%0d", tag, out_hit, out_t, out_idx, out_count);
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        chk({tag, "_exit_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_exit_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic                    mh;
        logic signed [WIDTH-1:0] mt;
        logic [IDX_W-1:0]        mi;
        logic signed [WIDTH-1:0] held_t;
        logic [IDX_W-1:0]        held_idx;
        logic [1:0]              rc;
        int                      rt;
        int                      n;

        rst = 1'b1; in_valid = 1'b0; in_t = '0; in_code = 2'b00;
        in_idx = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_hit", {63'd0, out_hit}, 64'd0);
        chk("rst_out_t", {32'd0, out_t}, 64'd0);
        chk("rst_out_idx", {54'd0, out_idx}, 64'd0);
        chk("rst_out_count", {54'd0, out_count}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Nearest of several hits, a miss with smaller t ignored
        push(1'b1, 2 * ONE, 1, 4);
        send(2'b01, 5 * ONE, 0, 1'b0);
        send(2'b01, 2 * ONE, 1, 1'b0);
        send(2'b00, 1 * ONE, 2, 1'b0);
        send(2'b01, 3 * ONE, 3, 1'b1);
        in_valid = 1'b0;
        chk("basic_latency", {63'd0, out_valid}, 64'd1);
        wait_check("basic");
        release_result("basic");

        // No qualifying result: behind-origin, degenerate, miss, negative t
        push(1'b0, 0, 0, 4);
        send(2'b11, 1 * ONE, 4, 1'b0);
        send(2'b10, 1 * ONE, 5, 1'b0);
        send(2'b00, 1 * ONE, 6, 1'b0);
        send(2'b01, -ONE, 8, 1'b1);
        in_valid = 1'b0;
        wait_check("nohit");
        release_result("nohit");

        // t == 0 does not qualify, smallest positive t does
        push(1'b1, 1, 4, 2);
        send(2'b01, 0, 2, 1'b0);
        send(2'b01, 1, 4, 1'b1);
        in_valid = 1'b0;
        wait_check("tzero");
        release_result("tzero");

        // Equal distances keep the earlier triangle
        push(1'b1, 4 * ONE, 7, 2);
        send(2'b01, 4 * ONE, 7, 1'b0);
        send(2'b01, 4 * ONE, 9, 1'b1);
        in_valid = 1'b0;
        wait_check("tie");
        release_result("tie");

        // Back-pressure: outputs frozen, garbage on the input never accepted
        push(1'b1, 5 * ONE / 2, 6, 2);
        send(2'b01, 3 * ONE, 5, 1'b0);
        send(2'b01, 5 * ONE / 2, 6, 1'b1);
        in_code = 2'b01; in_t = 1; in_idx = 10'd99; in_last = 1'b1;
        wait_check("stall");
        held_t   = out_t;
        held_idx = out_idx;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_t", {32'd0, out_t}, {32'd0, held_t});
            chk("stall_idx", {54'd0, out_idx}, {54'd0, held_idx});
        end
        release_result("stall");
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("post_stall_idle", {63'd0, out_valid}, 64'd0);
        end

        // Reset mid-ray discards it; the following ray counts from 1
        send(2'b01, 1 * ONE, 1, 1'b0);
        send(2'b01, 2 * ONE, 2, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_no_valid", {63'd0, out_valid}, 64'd0);
        end
        push(1'b1, 3 * ONE / 2, 3, 1);
        send(2'b01, 3 * ONE / 2, 3, 1'b1);
        in_valid = 1'b0;
        chk("single_latency", {63'd0, out_valid}, 64'd1);
        wait_check("single");
        release_result("single");

        // Long random ray: count saturates, nearest tracked by a reference model
        n  = 1030;
        mh = 1'b0; mt = '0; mi = '0;
        for (int i = 0; i < n; i++) begin
            rc = 2'($urandom_range(0, 3));
            rt = int'($urandom_range(0, 400)) - 100;
            if (rc == 2'b01 && rt > 0 && (!mh || rt < mt)) begin
                mh = 1'b1;
                mt = rt;
                mi = IDX_W'(i);
            end
            if (i == n - 1) begin
                push(mh, mh ? int'(mt) : 0, mh ? int'(mi) : 0, (1 << IDX_W) - 1);
            end
            send(rc, rt, i, i == n - 1);
        end
        in_valid = 1'b0;
        wait_check("long");
        release_result("long");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
